// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register slice, PC/IR/MAR/MDR/Y/Z/HI/LO and a combinational ALU.
// Define DATAPATH_EXT_SEL_EN to add s_R1/s_HI/s_LO/s_Zhigh as lowest-priority bus sources.
module data_path #(
    parameter int WIDTH = 32
) (
    input  logic               w_clock,
    input  logic               w_clear,
    input  logic               w_IncPC,
    input  logic               e_R1,
    input  logic               e_R2,
    input  logic               e_R3,
    input  logic               e_R4,
    input  logic               e_R5,
    input  logic               e_MAR,
    input  logic               e_PC,
    input  logic               e_IR,
    input  logic               e_Y,
    input  logic               e_HI,
    input  logic               e_LO,
    input  logic               e_MDR,
    input  logic               e_Z,
    input  logic               e_alu,
    input  logic               s_PC,
    input  logic               s_Zlow,
    input  logic               s_MDR,
    input  logic               s_R2,
    input  logic               s_R3,
    input  logic               s_R4,
    input  logic               s_R5,
`ifdef DATAPATH_EXT_SEL_EN
    input  logic               s_R1,
    input  logic               s_HI,
    input  logic               s_LO,
    input  logic               s_Zhigh,
`endif
    input  logic               w_read,
    input  logic [5:0]         opcode,
    input  logic [WIDTH-1:0]   w_Mdatain,
    output logic [WIDTH-1:0]   bus_q,
    output logic [WIDTH-1:0]   r1_q,
    output logic [WIDTH-1:0]   pc_q,
    output logic [WIDTH-1:0]   ir_q,
    output logic [WIDTH-1:0]   mar_q,
    output logic [WIDTH-1:0]   mdr_q,
    output logic [WIDTH-1:0]   y_q,
    output logic [WIDTH-1:0]   hi_q,
    output logic [WIDTH-1:0]   lo_q,
    output logic [2*WIDTH-1:0] z_q
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   r2_q, r3_q, r4_q, r5_q;
    logic [WIDTH-1:0]   mdr_d;
    logic [2*WIDTH-1:0] z_d;
    logic [2*WIDTH-1:0] alu_r;
    logic [4:0]         op;
    logic               unused_opcode_msb;

    logic [WIDTH-1:0]        a, b;
    logic [SW-1:0]           shamt;
    logic [WIDTH-1:0]        sum, diff, neg, incd, shr_r, shl_r, shra_r;
    logic [WIDTH-1:0]        rol_r, rol_unused_lo, ror_r, ror_unused_hi;
    logic signed [WIDTH-1:0] quot, rem;
    logic [2*WIDTH-1:0]      prod;

    // Fixed-priority bus source mux; nothing selected drives zero.
    always_comb begin
        bus_q = '0;
        if (s_PC)        bus_q = pc_q;
        else if (s_Zlow) bus_q = z_q[WIDTH-1:0];
        else if (s_MDR)  bus_q = mdr_q;
        else if (s_R2)   bus_q = r2_q;
        else if (s_R3)   bus_q = r3_q;
        else if (s_R4)   bus_q = r4_q;
        else if (s_R5)   bus_q = r5_q;
`ifdef DATAPATH_EXT_SEL_EN
        else if (s_R1)    bus_q = r1_q;
        else if (s_HI)    bus_q = hi_q;
        else if (s_LO)    bus_q = lo_q;
        else if (s_Zhigh) bus_q = z_q[2*WIDTH-1:WIDTH];
`endif
    end

    assign op                = opcode[4:0];
    assign unused_opcode_msb = opcode[5];
    assign a     = y_q;
    assign b     = bus_q;
    assign shamt = b[SW-1:0];

    assign sum    = a + b;
    assign diff   = a - b;
    assign neg    = '0 - b;
    assign incd   = bus_q + ONE;
    assign shr_r  = a >> shamt;
    assign shl_r  = a << shamt;
    assign shra_r = $signed(a) >>> shamt;
    assign {rol_r, rol_unused_lo} = {a, a} << shamt;
    assign {ror_unused_hi, ror_r} = {a, a} >> shamt;
    assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign quot = $signed(a) / $signed(b);
    assign rem  = $signed(a) % $signed(b);

    always_comb begin
        alu_r = '0;
        case (op)
            5'd0:  alu_r = {{WIDTH{1'b0}}, sum};
            5'd1:  alu_r = {{WIDTH{1'b0}}, diff};
            5'd2:  alu_r = {{WIDTH{1'b0}}, a & b};
            5'd3:  alu_r = {{WIDTH{1'b0}}, a | b};
            5'd4:  alu_r = {{WIDTH{1'b0}}, ~b};
            5'd5:  alu_r = prod;
            // Divide by zero reports all-ones quotient and passes the dividend through as remainder.
            5'd6:  alu_r = (b == '0) ? {a, {WIDTH{1'b1}}} : {rem, quot};
            5'd7:  alu_r = {{WIDTH{1'b0}}, rol_r};
            5'd8:  alu_r = {{WIDTH{1'b0}}, ror_r};
            5'd9:  alu_r = {{WIDTH{1'b0}}, shr_r};
            5'd10: alu_r = {{WIDTH{1'b0}}, shra_r};
            5'd11: alu_r = {{WIDTH{1'b0}}, shl_r};
            5'd12: alu_r = {{WIDTH{1'b0}}, neg};
            default: alu_r = '0;
        endcase
    end

    assign mdr_d = w_read ? w_Mdatain : bus_q;
    assign z_d   = w_IncPC ? {{WIDTH{1'b0}}, incd} : alu_r;

    always_ff @(posedge w_clock or posedge w_clear) begin
        if (w_clear) begin
            r1_q  <= '0;
            r2_q  <= '0;
            r3_q  <= '0;
            r4_q  <= '0;
            r5_q  <= '0;
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            y_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
        end else begin
            if (e_R1)  r1_q  <= bus_q;
            if (e_R2)  r2_q  <= bus_q;
            if (e_R3)  r3_q  <= bus_q;
            if (e_R4)  r4_q  <= bus_q;
            if (e_R5)  r5_q  <= bus_q;
            if (e_PC)  pc_q  <= bus_q;
            if (e_IR)  ir_q  <= bus_q;
            if (e_MAR) mar_q <= bus_q;
            if (e_Y)   y_q   <= bus_q;
            if (e_HI)  hi_q  <= bus_q;
            if (e_LO)  lo_q  <= bus_q;
            if (e_MDR) mdr_q <= mdr_d;
            // Z only captures a qualified result: PC increment or a valid ALU output.
            if (e_Z && (w_IncPC || e_alu)) z_q <= z_d;
        end
    end
endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed control sequences, an ALU vector table,
// and randomized ALU/increment operations checked against an arithmetic reference model.
module tb_data_path;
    logic        w_clock = 1'b0;
    logic        w_clear, w_IncPC;
    logic        e_R1, e_R2, e_R3, e_R4, e_R5, e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z, e_alu;
    logic        s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5;
    logic        w_read;
    logic [5:0]  opcode;
    logic [31:0] w_Mdatain;
    logic [31:0] bus_q, r1_q, pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
    logic [63:0] z_q;
`ifdef DATAPATH_EXT_SEL_EN
    logic        s_R1 = 1'b0, s_HI = 1'b0, s_LO = 1'b0, s_Zhigh = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    data_path #(.WIDTH(32)) dut (
        .w_clock(w_clock), .w_clear(w_clear), .w_IncPC(w_IncPC),
        .e_R1(e_R1), .e_R2(e_R2), .e_R3(e_R3), .e_R4(e_R4), .e_R5(e_R5),
        .e_MAR(e_MAR), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_HI(e_HI), .e_LO(e_LO),
        .e_MDR(e_MDR), .e_Z(e_Z), .e_alu(e_alu),
        .s_PC(s_PC), .s_Zlow(s_Zlow), .s_MDR(s_MDR), .s_R2(s_R2), .s_R3(s_R3),
        .s_R4(s_R4), .s_R5(s_R5),
`ifdef DATAPATH_EXT_SEL_EN
        .s_R1(s_R1), .s_HI(s_HI), .s_LO(s_LO), .s_Zhigh(s_Zhigh),
`endif
        .w_read(w_read), .opcode(opcode), .w_Mdatain(w_Mdatain),
        .bus_q(bus_q), .r1_q(r1_q), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q),
        .mdr_q(mdr_q), .y_q(y_q), .hi_q(hi_q), .lo_q(lo_q), .z_q(z_q)
    );

    always #5 w_clock = ~w_clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        {w_IncPC, e_R1, e_R2, e_R3, e_R4, e_R5, e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO} = '0;
        {e_MDR, e_Z, e_alu, s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5, w_read} = '0;
        opcode = '0;
    endtask

    // One controller step: hold the current controls across a rising edge, then clear them.
    task automatic tick();
        @(posedge w_clock);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        w_Mdatain = v; w_read = 1'b1; e_MDR = 1'b1;
        tick();
    endtask

    // Y <- a, then Z <- ALU(Y, b) with b presented on the bus from MDR.
    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        mem_to_mdr(a);
        s_MDR = 1'b1; e_Y = 1'b1;
        tick();
        mem_to_mdr(b);
        s_MDR = 1'b1; opcode = op; e_alu = 1'b1; e_Z = 1'b1;
        tick();
    endtask

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        logic [63:0] r;
        logic [31:0] t;
        longint sa, sb, ma, mb, q, m;
        int n;
        r  = '0;
        n  = int'(b[4:0]);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op[4:0])
            5'd0: begin t = a + b; r[31:0] = t; end
            5'd1: begin t = a - b; r[31:0] = t; end
            5'd2: r[31:0] = a & b;
            5'd3: r[31:0] = a | b;
            5'd4: r[31:0] = ~b;
            5'd5: r = sa * sb;
            5'd6: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    m  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) m = -m;
                    r = {m[31:0], q[31:0]};
                end
            end
            5'd7: for (int i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
            5'd8: for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
            5'd9: r[31:0] = a / (32'd1 << n);
            5'd10: for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? a[i + n] : a[31];
            5'd11: begin t = a * (32'd1 << n); r[31:0] = t; end
            5'd12: begin t = 32'd0 - b; r[31:0] = t; end
            default: r = '0;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] a, b, v;
        logic [5:0]  op;
        logic [63:0] exp, z_prev;

        vecs[0]  = '{32'd15,         32'hFFFF_FFFB, 6'd0,  64'h0000_0000_0000_000A};
        vecs[1]  = '{32'd15,         32'hFFFF_FFFB, 6'd1,  64'h0000_0000_0000_0014};
        vecs[2]  = '{32'hF0F0_F0F0,  32'hFF00_FF00, 6'd2,  64'h0000_0000_F000_F000};
        vecs[3]  = '{32'hF0F0_F0F0,  32'hFF00_FF00, 6'd3,  64'h0000_0000_FFF0_FFF0};
        vecs[4]  = '{32'h1234_5678,  32'h0000_FFFF, 6'd4,  64'h0000_0000_FFFF_0000};
        vecs[5]  = '{32'hFFFF_FFFA,  32'd4,         6'd5,  64'hFFFF_FFFF_FFFF_FFE8};
        vecs[6]  = '{32'hFFFF_FFFA,  32'd4,         6'd6,  64'hFFFF_FFFE_FFFF_FFFF};
        vecs[7]  = '{32'hFFFF_FFFA,  32'd0,         6'd6,  64'hFFFF_FFFA_FFFF_FFFF};
        vecs[8]  = '{32'h8000_0001,  32'd1,         6'd7,  64'h0000_0000_0000_0003};
        vecs[9]  = '{32'h8000_0001,  32'd1,         6'd8,  64'h0000_0000_C000_0000};
        vecs[10] = '{32'h8000_0001,  32'd1,         6'd9,  64'h0000_0000_4000_0000};
        vecs[11] = '{32'h8000_0001,  32'd1,         6'd10, 64'h0000_0000_C000_0000};
        vecs[12] = '{32'h8000_0001,  32'd1,         6'd11, 64'h0000_0000_0000_0002};
        vecs[13] = '{32'h0000_0000,  32'd5,         6'd12, 64'h0000_0000_FFFF_FFFB};
        vecs[14] = '{32'h1111_1111,  32'h2222_2222, 6'd13, 64'h0000_0000_0000_0000};
        vecs[15] = '{32'd1,          32'd2,         6'h20, 64'h0000_0000_0000_0003};
        vecs[16] = '{32'hFFFF_FFFF,  32'd1,         6'd0,  64'h0000_0000_0000_0000};

        idle();
        w_Mdatain = 32'hDEAD_BEEF;
        w_clear   = 1'b1;
        // Reset with every load enabled: clear must win.
        {e_R1, e_R2, e_R3, e_R4, e_R5, e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO} = '1;
        {e_MDR, e_Z, e_alu, w_IncPC, w_read} = '1;
        repeat (2) @(posedge w_clock);
        #1;
        check("rst_pc",  {32'd0, pc_q},  64'd0);
        check("rst_mdr", {32'd0, mdr_q}, 64'd0);
        check("rst_r1",  {32'd0, r1_q},  64'd0);
        check("rst_y",   {32'd0, y_q},   64'd0);
        check("rst_z",   z_q,            64'd0);
        check("rst_all", {32'd0, ir_q | mar_q | hi_q | lo_q}, 64'd0);
        idle();
        w_clear = 1'b0;
        tick();

        // Load path through MDR into R2, R3, R1.
        mem_to_mdr(32'd15);
        check("mdr_15", {32'd0, mdr_q}, 64'd15);
        s_MDR = 1'b1; e_R2 = 1'b1; tick();
        mem_to_mdr(32'hFFFF_FFFB);
        s_MDR = 1'b1; e_R3 = 1'b1; tick();
        mem_to_mdr(32'h18);
        s_MDR = 1'b1; e_R1 = 1'b1; tick();
        check("r1_18", {32'd0, r1_q}, 64'h18);
        s_R2 = 1'b1; #1;
        check("bus_r2", {32'd0, bus_q}, 64'd15);
        idle(); s_R3 = 1'b1; #1;
        check("bus_r3", {32'd0, bus_q}, 64'hFFFF_FFFB);
        idle();

        // Fetch sequence.
        s_PC = 1'b1; e_MAR = 1'b1; w_IncPC = 1'b1; e_Z = 1'b1; opcode = 6'd4; tick();
        check("fetch_mar", {32'd0, mar_q}, 64'd0);
        check("fetch_z",   z_q,            64'd1);
        w_Mdatain = 32'h2891_8000;
        s_Zlow = 1'b1; e_PC = 1'b1; w_read = 1'b1; e_MDR = 1'b1; tick();
        check("fetch_pc",  {32'd0, pc_q},  64'd1);
        check("fetch_mdr", {32'd0, mdr_q}, 64'h2891_8000);
        s_MDR = 1'b1; e_IR = 1'b1; tick();
        check("fetch_ir",  {32'd0, ir_q},  64'h2891_8000);

        // Sub from the register file, result to R1 and LO.
        s_R2 = 1'b1; e_Y = 1'b1; tick();
        check("sub_y", {32'd0, y_q}, 64'd15);
        s_R3 = 1'b1; opcode = 6'd1; e_alu = 1'b1; e_Z = 1'b1; tick();
        check("sub_z", z_q, 64'd20);
        s_Zlow = 1'b1; e_R1 = 1'b1; e_LO = 1'b1; tick();
        check("sub_r1", {32'd0, r1_q}, 64'd20);
        check("sub_lo", {32'd0, lo_q}, 64'd20);

        // Bus priority: PC=1, Zlow=20, MDR=0x28918000, R2=15, R3=-5.
        s_PC = 1'b1; s_R2 = 1'b1; #1;
        check("prio_pc_r2", {32'd0, bus_q}, 64'd1);
        idle(); s_Zlow = 1'b1; s_MDR = 1'b1; s_R5 = 1'b1; #1;
        check("prio_z_mdr", {32'd0, bus_q}, 64'd20);
        idle(); s_MDR = 1'b1; s_R2 = 1'b1; #1;
        check("prio_mdr_r2", {32'd0, bus_q}, 64'h2891_8000);
        idle(); s_R3 = 1'b1; s_R4 = 1'b1; #1;
        check("prio_r3_r4", {32'd0, bus_q}, 64'hFFFF_FFFB);
        idle(); #1;
        check("bus_none", {32'd0, bus_q}, 64'd0);

        // Self-load of the bus source plus a simultaneous HI load.
        s_R2 = 1'b1; e_R2 = 1'b1; e_HI = 1'b1; tick();
        check("self_hi", {32'd0, hi_q}, 64'd15);
        s_R2 = 1'b1; #1;
        check("self_r2", {32'd0, bus_q}, 64'd15);
        idle();

        // Z must hold without a qualifier, and without e_Z.
        s_R2 = 1'b1; e_Z = 1'b1; opcode = 6'd0; tick();
        check("z_hold_noalu", z_q, 64'd20);
        s_R2 = 1'b1; e_alu = 1'b1; opcode = 6'd0; tick();
        check("z_hold_noez", z_q, 64'd20);

        // ALU vector table.
        for (int i = 0; i < 17; i++) begin
            alu_run(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("vec%0d", i), z_q, vecs[i].exp);
        end

        // Randomized ALU operations and PC increments against the reference model.
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 9 == 0) b = 32'd0;
            op = 6'($urandom_range(0, 15)) | (6'($urandom_range(0, 1)) << 5);
            if (op[4:0] == 5'd6 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            if (i % 5 == 4) begin
                v = (i % 10 == 4) ? 32'hFFFF_FFFF : a;
                mem_to_mdr(v);
                s_MDR = 1'b1; w_IncPC = 1'b1; e_Z = 1'b1; e_alu = 1'($urandom_range(0, 1)); opcode = op;
                tick();
                exp = {32'd0, v + 32'd1};
                check($sformatf("rnd_inc%0d", i), z_q, exp);
            end else begin
                alu_run(a, b, op);
                exp = ref_alu(a, b, op);
                check($sformatf("rnd_alu%0d op%0h", i, op), z_q, exp);
            end
        end

        // Asynchronous clear mid-step aborts pending loads.
        z_prev = z_q;
        check("pre_clear_z_nonzero", {63'd0, z_prev != 64'd0}, 64'd1);
        mem_to_mdr(32'hCAFE_0001);
        s_MDR = 1'b1; e_R1 = 1'b1; e_PC = 1'b1; e_Y = 1'b1;
        #2 w_clear = 1'b1;
        #1;
        check("aclr_z",   z_q, 64'd0);
        check("aclr_mdr", {32'd0, mdr_q}, 64'd0);
        @(posedge w_clock); #1;
        check("aclr_hold", {32'd0, r1_q | pc_q | y_q | hi_q | lo_q}, 64'd0);
        idle();
        w_clear = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath: register file slice (R1–R5), PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, and a combinational ALU.
- All register outputs share one bus through a select mux. The ALU takes A = Y and B = bus, and its result is captured in Z.
- Sits under the control unit, which drives every load enable, bus select and ALU opcode one clock step at a time.

Parameters:
- WIDTH, 32, datapath/bus width; all registers are WIDTH bits, Z is 2*WIDTH.

Ports:
- w_clock  in  1  system clock, rising-edge active
- w_clear  in  1  asynchronous active-high reset
- w_IncPC  in  1  Z input becomes bus+1 (PC increment), overrides opcode
- e_R1..e_R5  in  1 each  load enable of R1..R5 from bus
- e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO  in  1 each  load enable from bus
- e_MDR  in  1  MDR load enable (source chosen by w_read)
- e_Z  in  1  Z (64-bit) load enable
- e_alu  in  1  ALU result valid for Z capture
- s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5  in  1 each  bus source selects
- w_read  in  1  MDR source: 1 = w_Mdatain, 0 = bus
- opcode  in  6  ALU operation; bits [4:0] decoded, bit 5 ignored
- w_Mdatain  in  32  memory data in
- bus_q, r1_q, pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q  out  32 each  observation taps
- z_q  out  64  Z register {Zhigh, Zlow}

Behaviour:
- Reset: w_clear high → every register (R1–R5, PC, IR, MAR, MDR, Y, Z, HI, LO) = 0 immediately, held while asserted. All outputs read 0.
- Register loads occur on the rising w_clock edge when the corresponding enable is high; otherwise the register holds.
- Bus is combinational. Fixed priority when several selects are high: PC > Zlow > MDR > R2 > R3 > R4 > R5. No select → bus = 0.
- MDR D-input = w_read ? w_Mdatain : bus.
- R1 has no bus select; it is observable only via r1_q.
- HI/LO load from the bus.
- ALU (A = Y, B = bus) result R[63:0]; Zhigh = 0 unless stated:
  - 00000 add: A+B
  - 00001 sub: A−B
  - 00010 and: A&B
  - 00011 or: A|B
  - 00100 not: ~B
  - 00101 mul: signed 64-bit A*B
  - 00110 div: signed; Zlow = quotient (truncate toward 0), Zhigh = remainder (sign of A). B=0 → Zlow = 0xFFFFFFFF, Zhigh = A.
  - 00111 rol / 01000 ror: A rotated by B[4:0]
  - 01001 shr: logical right by B[4:0]
  - 01010 shra: arithmetic right by B[4:0]
  - 01011 shl: left by B[4:0]
  - 01100 neg: −B
  - Other codes: R = 0.
- Add/sub wrap modulo 2^32; no flags.
- Z input = w_IncPC ? {32'b0, bus+1} : R.
- Z loads on the clock edge when e_Z is high and (w_IncPC or e_alu). e_Z with neither → Z holds.
- Simultaneous load of several registers from the same bus value is legal. A register that is both the bus source and a load target loads its own old value.
- Reset mid-sequence aborts all pending loads. No state machine inside; sequencing is the controller's job.

Optional Feature:
- DATAPATH_EXT_SEL_EN defined: adds input ports s_R1, s_HI, s_LO, s_Zhigh as additional bus sources, lowest priority, in that order after s_R5.
- Undefined: those ports do not exist and those registers are never bus sources.

Test Plan:
- Reset: pulse w_clear with loads enabled → all taps 0, z_q = 0.
- Load path: w_Mdatain=15, w_read=1, e_MDR=1 → mdr_q=15. Then s_MDR, e_R2 → R2=15. Repeat: R3=0xFFFFFFFB (−5), R1=0x18.
- Fetch sequence:
  - s_PC, e_MAR, w_IncPC, e_Z (PC=0) → mar_q=0, Zlow=1.
  - s_Zlow, e_PC, w_read, e_MDR with w_Mdatain=0x28918000 → pc_q=1, mdr_q=0x28918000.
  - s_MDR, e_IR → ir_q=0x28918000.
- Sub: s_R2, e_Y → y_q=15. s_R3, opcode=sub, e_alu, e_Z → Zlow=20. s_Zlow, e_R1, e_LO → r1_q=20, lo_q=20.
- Mul/div: Y=−6, B=4:
  - mul → z_q = 0xFFFFFFFF_FFFFFFE8.
  - div → Zlow = 0xFFFFFFFF (−1), Zhigh = 0xFFFFFFFE (−2).
  - B=0 → Zlow = 0xFFFFFFFF, Zhigh = 0xFFFFFFFA.
- Shifts: Y=0x80000001, B=1:
  - rol=0x00000003
  - ror=0xC0000000
  - shr=0x40000000
  - shra=0xC0000000
  - shl=0x00000002
- Bus priority: s_PC and s_R2 both high → bus_q = pc_q.
